// File: rtl/bp_me_pkg.sv
// Shared definitions for the BP burst/lite conversion blocks.
//   bp_me_state_e    : converter FSM states
//   bp_me_beats      : data beats carried by a message of 2^size bytes
//   bp_me_rep_factor : how many copies of the payload fill one block
package bp_me_pkg;

    typedef enum logic [1:0] {
        e_ready,
        e_data,
        e_send
    } bp_me_state_e;

    // At least one beat, even for sub-beat sizes. Clamped to one full block
    // when the header claims more bytes than a block holds.
    function automatic int bp_me_beats(input int size, input int beat_w, input int block_w);
        int bits;
        int n;
        bits = 8 << size;
        n    = bits / beat_w;
        if (n < 1)                n = 1;
        if (n > block_w / beat_w) n = block_w / beat_w;
        return n;
    endfunction

    // Payloads smaller than a block are tiled; oversize payloads count as one copy.
    function automatic int bp_me_rep_factor(input int size, input int block_w);
        int bits;
        bits = 8 << size;
        if (bits > block_w) bits = block_w;
        return block_w / bits;
    endfunction

endpackage

// File: rtl/bp_me_burst_header_decode.sv
// Combinational decode of a burst header.
//   header_i    : burst header
//   has_data_o  : msg_type is flagged in data_mask_p
//   beats_o     : number of data beats to collect
//   byte_mask_o : (payload bytes - 1); payload byte index mask used for tiling
//   oversize_o  : header size exceeds one block (only with BP_ME_BURST_TO_LITE_CHECK_EN)
module bp_me_burst_header_decode
    import bp_me_pkg::*;
#(
    parameter int header_width_p    = 64,
    parameter int beat_width_p      = 64,
    parameter int block_width_p     = 512,
    parameter int msg_type_offset_p = 0,
    parameter int msg_type_width_p  = 4,
    parameter int size_offset_p     = 4,
    parameter int size_width_p      = 3,
    parameter logic [(1<<msg_type_width_p)-1:0] data_mask_p = '0,
    parameter int cnt_w_p           = 4,
    parameter int byte_aw_p         = 6
) (
    input  logic [header_width_p-1:0] header_i,
    output logic                      has_data_o,
    output logic [cnt_w_p-1:0]        beats_o,
`ifdef BP_ME_BURST_TO_LITE_CHECK_EN
    output logic                      oversize_o,
`endif
    output logic [byte_aw_p-1:0]      byte_mask_o
);

    logic [msg_type_width_p-1:0] msg_type;
    logic [size_width_p-1:0]     size;
    logic                        unused_hdr_bits;

    assign msg_type        = header_i[msg_type_offset_p +: msg_type_width_p];
    assign size            = header_i[size_offset_p +: size_width_p];
    assign unused_hdr_bits = ^header_i;

    assign has_data_o  = data_mask_p[msg_type];
    assign beats_o     = cnt_w_p'(bp_me_beats(int'(size), beat_width_p, block_width_p));
    assign byte_mask_o = byte_aw_p'((block_width_p / 8)
                         / bp_me_rep_factor(int'(size), block_width_p) - 1);
`ifdef BP_ME_BURST_TO_LITE_CHECK_EN
    assign oversize_o  = (8 << int'(size)) > block_width_p;
`endif

endmodule

// File: rtl/bp_me_burst_to_lite.sv
// Assembles a BP burst (header channel + data-beat channel) into one lite
// message: header plus a full block payload, handed off valid->yumi.
//   clk_i, reset_i             : clock, synchronous active-high reset
//   header_i/_v_i/_ready_o     : burst header channel
//   data_i/_v_i/_ready_o       : burst data-beat channel
//   msg_header_o, msg_data_o   : assembled message, stable while msg_v_o
//   msg_v_o, msg_yumi_i        : message handshake
//   error_o                    : sticky protocol error when BP_ME_BURST_TO_LITE_CHECK_EN
//                                is defined (oversize header, yumi without valid);
//                                tied 0 otherwise
module bp_me_burst_to_lite
    import bp_me_pkg::*;
#(
    parameter int header_width_p    = 64,
    parameter int beat_width_p      = 64,
    parameter int block_width_p     = 512,
    parameter int msg_type_offset_p = 0,
    parameter int msg_type_width_p  = 4,
    parameter int size_offset_p     = 4,
    parameter int size_width_p      = 3,
    parameter logic [(1<<msg_type_width_p)-1:0] data_mask_p = '0
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [header_width_p-1:0] header_i,
    input  logic                      header_v_i,
    output logic                      header_ready_o,
    input  logic [beat_width_p-1:0]   data_i,
    input  logic                      data_v_i,
    output logic                      data_ready_o,
    output logic [header_width_p-1:0] msg_header_o,
    output logic [block_width_p-1:0]  msg_data_o,
    output logic                      msg_v_o,
    input  logic                      msg_yumi_i,
    output logic                      error_o
);

    localparam int max_beats_lp   = block_width_p / beat_width_p;
    localparam int cnt_w_lp       = $clog2(max_beats_lp) + 1;
    localparam int block_bytes_lp = block_width_p / 8;
    localparam int byte_aw_lp     = (block_bytes_lp > 1) ? $clog2(block_bytes_lp) : 1;

    bp_me_state_e              state_r, state_n;
    logic [header_width_p-1:0] hdr_r, hdr_n;
    logic [block_width_p-1:0]  data_r, data_n, data_wr, data_rep;
    logic [cnt_w_lp-1:0]       cnt_r, cnt_n, beats_r, beats_n;
    logic [byte_aw_lp-1:0]     bmask_r, bmask_n;

    logic                      dec_has_data;
    logic [cnt_w_lp-1:0]       dec_beats;
    logic [byte_aw_lp-1:0]     dec_bmask;
`ifdef BP_ME_BURST_TO_LITE_CHECK_EN
    logic                      dec_oversize;
`endif

    bp_me_burst_header_decode #(
        .header_width_p   (header_width_p),
        .beat_width_p     (beat_width_p),
        .block_width_p    (block_width_p),
        .msg_type_offset_p(msg_type_offset_p),
        .msg_type_width_p (msg_type_width_p),
        .size_offset_p    (size_offset_p),
        .size_width_p     (size_width_p),
        .data_mask_p      (data_mask_p),
        .cnt_w_p          (cnt_w_lp),
        .byte_aw_p        (byte_aw_lp)
    ) u_decode (
        .header_i   (header_i),
        .has_data_o (dec_has_data),
        .beats_o    (dec_beats),
`ifdef BP_ME_BURST_TO_LITE_CHECK_EN
        .oversize_o (dec_oversize),
`endif
        .byte_mask_o(dec_bmask)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_ready;
            hdr_r   <= '0;
            data_r  <= '0;
            cnt_r   <= '0;
            beats_r <= '0;
            bmask_r <= '0;
        end else begin
            state_r <= state_n;
            hdr_r   <= hdr_n;
            data_r  <= data_n;
            cnt_r   <= cnt_n;
            beats_r <= beats_n;
            bmask_r <= bmask_n;
        end
    end

    always_comb begin
        state_n        = state_r;
        hdr_n          = hdr_r;
        data_n         = data_r;
        cnt_n          = cnt_r;
        beats_n        = beats_r;
        bmask_n        = bmask_r;
        header_ready_o = 1'b0;
        data_ready_o   = 1'b0;
        msg_v_o        = 1'b0;

        // Current beat dropped into its slot.
        data_wr = data_r;
        for (int k = 0; k < max_beats_lp; k++)
            if (cnt_r == cnt_w_lp'(k))
                data_wr[k*beat_width_p +: beat_width_p] = data_i;

        // Tile the payload: byte i takes byte (i & bmask_r). Each stage folds
        // one clear mask bit by mirroring the lower half onto the upper half.
        data_rep = data_wr;
        for (int s = 0; s < byte_aw_lp; s++)
            if (!bmask_r[s])
                for (int i = 0; i < block_width_p; i++)
                    if (((i >> (3 + s)) & 1) == 1)
                        data_rep[i] = data_rep[i - (8 << s)];

        case (state_r)
            e_ready: begin
                header_ready_o = 1'b1;
                if (header_v_i) begin
                    hdr_n   = header_i;
                    beats_n = dec_beats;
                    bmask_n = dec_bmask;
                    cnt_n   = '0;
                    if (dec_has_data) begin
                        state_n = e_data;
                    end else begin
                        data_n  = '0;
                        state_n = e_send;
                    end
                end
            end
            e_data: begin
                data_ready_o = 1'b1;
                if (data_v_i) begin
                    cnt_n = cnt_r + cnt_w_lp'(1);
                    if (cnt_r == beats_r - cnt_w_lp'(1)) begin
                        data_n  = data_rep;
                        state_n = e_send;
                    end else begin
                        data_n  = data_wr;
                    end
                end
            end
            e_send: begin
                msg_v_o = 1'b1;
                if (msg_yumi_i) state_n = e_ready;
            end
            default: state_n = e_ready;
        endcase
    end

    assign msg_header_o = hdr_r;
    assign msg_data_o   = data_r;

`ifdef BP_ME_BURST_TO_LITE_CHECK_EN
    logic err_r;
    always_ff @(posedge clk_i) begin
        if (reset_i)
            err_r <= 1'b0;
        else if ((state_r == e_ready && header_v_i && dec_oversize) || (msg_yumi_i && !msg_v_o))
            err_r <= 1'b1;
    end
    assign error_o = err_r;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_me_burst_to_lite.sv
// Directed bench for bp_me_burst_to_lite: header msg_type[3:0], size[6:4],
// msg_type 1 carries data. Inputs change and outputs are checked on negedge.
module tb_bp_me_burst_to_lite;

    localparam int HW = 64;
    localparam int BW = 64;
    localparam int KW = 512;
`ifdef BP_ME_BURST_TO_LITE_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_i, header_v_i, data_v_i, msg_yumi_i;
    logic [HW-1:0] header_i;
    logic [BW-1:0] data_i;
    logic          header_ready_o, data_ready_o, msg_v_o, error_o;
    logic [HW-1:0] msg_header_o;
    logic [KW-1:0] msg_data_o;
    logic [KW-1:0] exp;

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    bp_me_burst_to_lite #(
        .header_width_p   (HW),
        .beat_width_p     (BW),
        .block_width_p    (KW),
        .msg_type_offset_p(0),
        .msg_type_width_p (4),
        .size_offset_p    (4),
        .size_width_p     (3),
        .data_mask_p      (16'h0002)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .header_i      (header_i),
        .header_v_i    (header_v_i),
        .header_ready_o(header_ready_o),
        .data_i        (data_i),
        .data_v_i      (data_v_i),
        .data_ready_o  (data_ready_o),
        .msg_header_o  (msg_header_o),
        .msg_data_o    (msg_data_o),
        .msg_v_o       (msg_v_o),
        .msg_yumi_i    (msg_yumi_i),
        .error_o       (error_o)
    );

    function automatic logic [HW-1:0] hdr(input logic [3:0] t, input logic [2:0] s);
        return {57'd0, s, t};
    endfunction

    task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] want);
        vec++;
        assert (obs === want) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic want);
        vec++;
        assert (obs === want) else begin
            miss++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_hdr(input logic [HW-1:0] h);
        header_i   = h;
        header_v_i = 1'b1;
        tick();
        header_v_i = 1'b0;
    endtask

    task automatic beat(input logic [BW-1:0] d);
        data_i   = d;
        data_v_i = 1'b1;
        tick();
        data_v_i = 1'b0;
    endtask

    task automatic yumi();
        msg_yumi_i = 1'b1;
        tick();
        msg_yumi_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; header_v_i = 1'b0; data_v_i = 1'b0; msg_yumi_i = 1'b0;
        header_i = '0; data_i = '0;
        repeat (2) tick();
        chk1("rst_v", msg_v_o, 1'b0);
        chk1("rst_hready", header_ready_o, 1'b1);
        chk1("rst_dready", data_ready_o, 1'b0);
        chk("rst_data", msg_data_o, '0);
        chk("rst_hdr", KW'(msg_header_o), '0);
        chk1("rst_err", error_o, 1'b0);
        reset_i = 1'b0;
        tick();

        // Read: no data, message one cycle after header.
        header_i = hdr(4'd0, 3'd6); header_v_i = 1'b1;
        chk1("rd_dready_pre", data_ready_o, 1'b0);
        tick(); header_v_i = 1'b0;
        chk1("rd_v_t1", msg_v_o, 1'b1);
        chk("rd_data", msg_data_o, '0);
        chk("rd_hdr", KW'(msg_header_o), KW'(hdr(4'd0, 3'd6)));
        chk1("rd_dready", data_ready_o, 1'b0);
        yumi();
        chk1("rd_done_v", msg_v_o, 1'b0);

        // Full 64 B write, beats 0x11..0x88.
        send_hdr(hdr(4'd1, 3'd6));
        chk1("wr_dready", data_ready_o, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) chk1("wr_v_early", msg_v_o, 1'b0);
            beat(64'h11 * (k + 1));
        end
        for (int k = 0; k < 8; k++) exp[k*64 +: 64] = 64'h11 * (k + 1);
        chk1("wr_v_t9", msg_v_o, 1'b1);
        chk("wr_lo", KW'(msg_data_o[63:0]), KW'(64'h11));
        chk("wr_hi", KW'(msg_data_o[511:448]), KW'(64'h88));
        chk("wr_full", msg_data_o, exp);
        chk1("wr_dready_send", data_ready_o, 1'b0);
        yumi();

        // 16 B: two beats tiled 4x.
        send_hdr(hdr(4'd1, 3'd4));
        beat(64'h0123456789ABCDEF);
        beat(64'hFEDCBA9876543210);
        chk1("s4_v", msg_v_o, 1'b1);
        chk("s4_data", msg_data_o, {4{64'hFEDCBA9876543210, 64'h0123456789ABCDEF}});
        yumi();

        // 4 B: low 32 bits of one beat tiled 16x; upper beat bits ignored.
        send_hdr(hdr(4'd1, 3'd2));
        beat(64'hCAFEF00DDEADBEEF);
        chk1("s2_v", msg_v_o, 1'b1);
        chk("s2_data", msg_data_o, {16{32'hDEADBEEF}});
        yumi();

        // Early data, held-off yumi, next header not taken during send.
        data_i = 64'h1000; data_v_i = 1'b1;
        repeat (3) begin
            chk1("early_dready", data_ready_o, 1'b0);
            tick();
        end
        header_i = hdr(4'd1, 3'd6); header_v_i = 1'b1;
        tick(); header_v_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            data_i = 64'h1000 + 64'(k); data_v_i = 1'b1;
            tick();
        end
        data_v_i = 1'b0;
        for (int k = 0; k < 8; k++) exp[k*64 +: 64] = 64'h1000 + 64'(k);
        header_i = hdr(4'd0, 3'd3); header_v_i = 1'b1;
        repeat (5) begin
            chk1("hold_v", msg_v_o, 1'b1);
            chk1("hold_hready", header_ready_o, 1'b0);
            chk("hold_data", msg_data_o, exp);
            chk("hold_hdr", KW'(msg_header_o), KW'(hdr(4'd1, 3'd6)));
            tick();
        end
        msg_yumi_i = 1'b1;
        chk1("yumi_hready", header_ready_o, 1'b0);
        tick(); msg_yumi_i = 1'b0;
        chk1("post_yumi_v", msg_v_o, 1'b0);
        chk1("post_yumi_hready", header_ready_o, 1'b1);
        tick(); header_v_i = 1'b0;
        chk1("next_v", msg_v_o, 1'b1);
        chk("next_hdr", KW'(msg_header_o), KW'(hdr(4'd0, 3'd3)));
        chk("next_data", msg_data_o, '0);
        yumi();

        // Reset mid-burst, then a fresh burst.
        send_hdr(hdr(4'd1, 3'd6));
        for (int k = 0; k < 3; k++) beat(64'hA0 + 64'(k));
        reset_i = 1'b1;
        tick();
        chk1("mid_rst_v", msg_v_o, 1'b0);
        chk1("mid_rst_dready", data_ready_o, 1'b0);
        chk("mid_rst_data", msg_data_o, '0);
        tick();
        chk1("mid_rst_v2", msg_v_o, 1'b0);
        reset_i = 1'b0;
        chk1("mid_rst_hready", header_ready_o, 1'b1);
        send_hdr(hdr(4'd1, 3'd6));
        for (int k = 0; k < 8; k++) beat(64'hB0 + 64'(k));
        for (int k = 0; k < 8; k++) exp[k*64 +: 64] = 64'hB0 + 64'(k);
        chk1("fresh_v", msg_v_o, 1'b1);
        chk("fresh_data", msg_data_o, exp);
        yumi();

        // Oversize 128 B header: clamped to 8 beats; 9th beat held off.
        send_hdr(hdr(4'd1, 3'd7));
        for (int k = 0; k < 8; k++) beat(64'hC0 + 64'(k));
        for (int k = 0; k < 8; k++) exp[k*64 +: 64] = 64'hC0 + 64'(k);
        data_i = 64'hFF; data_v_i = 1'b1;
        chk1("ovs_v", msg_v_o, 1'b1);
        chk1("ovs_dready", data_ready_o, 1'b0);
        chk("ovs_data", msg_data_o, exp);
        chk1("ovs_err", error_o, CHK);
        yumi();
        data_v_i = 1'b0;
        chk1("ovs_err_sticky", error_o, CHK);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk1("err_rst", error_o, 1'b0);

        // Yumi without valid.
        msg_yumi_i = 1'b1;
        tick();
        msg_yumi_i = 1'b0;
        chk1("spur_v", msg_v_o, 1'b0);
        chk1("spur_hready", header_ready_o, 1'b1);
        chk1("spur_err", error_o, CHK);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/bp_me_burst_to_lite.md
Name: bp_me_burst_to_lite

Overview:
- Converts a BP burst-protocol stream into a single assembled "lite" message: one header plus a full-block payload.
- The burst stream is a header channel plus a data-beat channel, each with ready&valid.
- Generalises the fixed dword-beat, fixed-width CCE burst ports: beat width, block width, header layout and which message types carry data are all parametrised.
- Sits at CCE/LCE/memory network endpoints, wherever a block consumes whole messages but the network delivers bursts.

Parameters:
- header_width_p, 64, width of the burst header.
- beat_width_p, 64, data bits per beat; power of two, at least 8.
- block_width_p, 512, assembled payload width; power-of-two multiple of beat_width_p.
- msg_type_offset_p, 0, LSB of the msg_type field in the header.
- msg_type_width_p, 4, width of msg_type.
- size_offset_p, 4, LSB of the size field (log2 bytes).
- size_width_p, 3, width of the size field.
- data_mask_p, 16'h0000, bit i set means msg_type i carries a data payload.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- header_i  in  header_width_p  burst header
- header_v_i  in  1  header valid
- header_ready_o  out  1  header ready; transfer when v&ready
- data_i  in  beat_width_p  data beat
- data_v_i  in  1  beat valid
- data_ready_o  out  1  beat ready
- msg_header_o  out  header_width_p  assembled header
- msg_data_o  out  block_width_p  assembled payload
- msg_v_o  out  1  message valid
- msg_yumi_i  in  1  consumer takes message (valid->yumi)
- error_o  out  1  sticky protocol error (optional feature only)

Behaviour:
- One clock, clk_i. reset_i is synchronous and active-high.
- Reset values: state e_ready, beat counter 0, header and data registers 0, msg_v_o 0, error_o 0.
- FSM e_ready:
  - header_ready_o=1, data_ready_o=0.
  - On a header transfer, latch the header and decode it.
  - If msg_type is set in data_mask_p: beats = max(1, 2^size*8/beat_width_p); counter <= 0; go to e_data.
  - Otherwise clear the data register and go to e_send.
- FSM e_data:
  - header_ready_o=0, data_ready_o=1.
  - Each beat k is written to slice [k*beat_width_p +: beat_width_p].
  - On the final beat (counter==beats-1), go to e_send.
- FSM e_send:
  - msg_v_o=1, both readies 0.
  - msg_header_o and msg_data_o are held stable until msg_yumi_i, then go to e_ready.
- Sub-block payloads (beats < block_width_p/beat_width_p): msg_data_o is the received beats replicated to fill block_width_p. Replication is resolved when entering e_send.
- Sub-beat sizes (2^size*8 < beat_width_p): one beat; the lowest 2^size*8 bits are replicated across the block.
- Latency: header accepted at cycle t, last beat at t+N, msg_v_o at t+N+1. No-data messages: msg_v_o at t+1.
- Throughput: at most one message per N+2 cycles. A header is never accepted in the same cycle as msg_yumi_i.
- Data beats presented before their header are legal. They are held off by data_ready_o=0, with no loss.
- Oversize header (size bytes > block bytes): beat count is clamped to block_width_p/beat_width_p.
- msg_yumi_i without msg_v_o is ignored.
- reset_i mid-burst aborts the message and returns to reset values. Upstream must re-send the complete burst.

Optional Feature:
- Macro: BP_ME_BURST_TO_LITE_CHECK_EN.
- When defined, error_o is set and held until reset on either of:
  - an oversize header;
  - msg_yumi_i asserted while msg_v_o=0.
- When not defined, error_o is tied 0 and no check logic is present.

Decomposition:
- Shared bp_me_pkg holds:
  - the FSM state enum (e_ready, e_data, e_send);
  - a function computing the beat count from size, beat_width_p and block_width_p;
  - a function computing the replication factor.
- Natural sub-module: bp_me_burst_header_decode (combinational field extraction, has_data, beats). The FSM and datapath stay in the top module.

Test Plan:
- Read cmd (msg_type 0, mask bit clear), size 6 -> msg_v_o at t+1, msg_data_o=0, data_ready_o never 1.
- Write, data_mask_p bit 1, size 6 (64 B), 8 beats 0x11..0x88 back-to-back -> msg_v_o at t+9, msg_data_o[63:0]=0x11, [511:448]=0x88.
- Size 4 (16 B), beats A,B -> msg_data_o = {B,A} replicated 4x; size 2 (4 B), beat 0xDEADBEEF -> 0xDEADBEEF replicated 16x.
- data_v_i asserted 3 cycles before header_v_i; msg_yumi_i withheld 5 cycles -> no beat lost; header_ready_o=0 during those 5 cycles; outputs stable.
- reset_i after beat 3 of 8, then a fresh 8-beat write -> msg_data_o contains only new beats; msg_v_o=0 throughout reset.
- With BP_ME_BURST_TO_LITE_CHECK_EN, size 7 (128 B) header -> error_o=1 until reset; exactly 8 beats consumed.
